// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Streams a program image into the RV32I instruction memory and keeps the
// CPU parked in reset until the whole image has arrived and its checksum has
// been verified.
//
// Stream layout (one byte per valid/ready handshake):
//   LEN_LO, LEN_HI        number of 32-bit words N (16-bit little-endian)
//   4*N data bytes        each word little-endian, written from word 0 up
//   CHK                   chosen so the XOR of every byte LEN_LO..CHK is 0
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   start         one-cycle pulse, restarts a load from DONE or ERROR
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader can take a byte this cycle
//   imem_we       one-cycle write strobe per assembled word
//   imem_addr     word address of the write
//   imem_wdata    assembled word
//   cpu_hold      1 keeps the CPU in reset, 0 lets it run
//   done          load finished with a good checksum
//   err           load aborted (length too large or bad checksum)
//   words_loaded  words written by the current or most recent load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_LEN0  = 3'd0;
    localparam logic [2:0] S_LEN1  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    // Largest word count that fits the memory; one bit wider than the
    // length field so the comparison cannot wrap.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]      state;
    logic [15:0]     len_q;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic [7:0]      chk_acc;

    logic            accept;
    logic [15:0]     len_full;
    logic [ADDR_W:0] next_count;
    logic            last_word;

    // A byte is consumed only on a real handshake, so whatever sits on
    // in_data while in_valid is low never reaches the checksum or the word.
    assign accept     = in_valid & in_ready;

    // Full length as it will look once LEN_HI is captured, used to pick the
    // next state in the same cycle the high byte arrives.
    assign len_full   = {in_data, len_q[7:0]};

    assign next_count = words_loaded + (ADDR_W + 1)'(1);
    assign last_word  = (16'(next_count) == len_q);

    // Main loader state machine. Every output is a register; in_ready is
    // updated together with the state so it drops in the same cycle the
    // loader enters DONE or ERROR and rises again when start is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LEN0;
            len_q        <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            chk_acc      <= '0;
            in_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;

            case (state)
                S_LEN0: begin
                    if (accept) begin
                        len_q[7:0] <= in_data;
                        chk_acc    <= chk_acc ^ in_data;
                        state      <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        chk_acc     <= chk_acc ^ in_data;
                        // Reject images larger than the memory before any
                        // word is written so existing contents survive.
                        if ({1'b0, len_full} > MAX_WORDS) begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        chk_acc  <= chk_acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                // The fourth byte goes straight into the
                                // write data, so the strobe appears on the
                                // very next cycle without stalling input.
                                imem_we      <= 1'b1;
                                imem_addr    <= words_loaded[ADDR_W-1:0];
                                imem_wdata   <= {in_data, word_buf};
                                words_loaded <= next_count;
                                if (last_word) begin
                                    state <= S_CHK;
                                end
                            end
                        endcase
                    end
                end

                S_CHK: begin
                    if (accept) begin
                        chk_acc  <= chk_acc ^ in_data;
                        in_ready <= 1'b0;
                        if ((chk_acc ^ in_data) == 8'h00) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    // Both end states hold until start; memory contents are
                    // deliberately left alone so a failed reload is visible.
                    if (start) begin
                        state        <= S_LEN0;
                        in_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        chk_acc      <= '0;
                        byte_idx     <= '0;
                        len_q        <= '0;
                    end
                end

                default: begin
                    state    <= S_LEN0;
                    in_ready <= 1'b1;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Drives byte streams into prog_loader and scores every instruction memory
// write against a queue of expected writes filled by the stimulus side.
// Expected words, addresses, write cycles and end-of-load status come from a
// simple model of the stream format: words are split into little-endian
// bytes, the checksum is the XOR of everything sent, and the outcome follows
// from the length and checksum alone.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int ADDR_W    = 7;
    localparam int MAX_WORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          when;
    } wr_t;

    wr_t exp_q[$];
    int  checks;
    int  errors;
    int  cyc;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Free-running clock and a cycle counter used to time write strobes.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the bench itself gets stuck somewhere.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        wr_t e;
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", 32'(imem_addr), e.addr);
                check_output("write_data", imem_wdata, e.data);
                check_output("write_cycle", cyc, e.when);
            end
        end
    end

    // Presents one byte after an optional idle gap and waits (bounded) until
    // the loader is ready; the handshake then happens on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int hs_cyc);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got in_ready 0 expected 1");
        end
        hs_cyc = cyc;
    endtask

    function automatic int pick_gap(input int gap_mode);
        if (gap_mode == 0) return 0;
        if (gap_mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    // Sends a complete load of n words. chk_mask is XORed into the correct
    // checksum (0 = good stream). abort_after > 0 pulls reset after that many
    // data bytes and stops there.
    task automatic apply_stimulus(input int n, input logic [31:0] words[$],
                                  input logic [7:0] chk_mask, input int gap_mode,
                                  input int abort_after);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w;
        logic [15:0] len;
        int          hs;
        int          sent;
        bit          ok;

        chk  = 8'h00;
        sent = 0;
        len  = 16'(n);

        send_byte(len[7:0], pick_gap(gap_mode), hs);
        chk ^= len[7:0];
        send_byte(len[15:8], pick_gap(gap_mode), hs);
        chk ^= len[15:8];

        if (n > MAX_WORDS) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_output("oversize_err", 32'(err), 1);
            check_output("oversize_done", 32'(done), 0);
            check_output("oversize_ready", 32'(in_ready), 0);
            check_output("oversize_hold", 32'(cpu_hold), 1);
            check_output("oversize_count", 32'(words_loaded), 0);
            return;
        end

        for (int wi = 0; wi < n; wi++) begin
            w = words[wi];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                send_byte(b, pick_gap(gap_mode), hs);
                chk ^= b;
                sent++;
                if (k == 3) exp_q.push_back('{addr: wi, data: w, when: hs + 1});
                if (abort_after > 0 && sent == abort_after) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    rst = 1'b0;
                    #1;
                    check_output("abort_hold", 32'(cpu_hold), 1);
                    check_output("abort_count", 32'(words_loaded), 0);
                    check_output("abort_ready", 32'(in_ready), 1);
                    check_output("abort_done", 32'(done), 0);
                    check_output("abort_pending", exp_q.size(), 0);
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
            end
        end

        ok = (chk_mask == 8'h00);
        send_byte(chk ^ chk_mask, pick_gap(gap_mode), hs);
        @(negedge clk);
        in_valid = 1'b0;
        check_output("end_done", 32'(done), 32'(ok));
        check_output("end_err", 32'(err), 32'(!ok));
        check_output("end_hold", 32'(cpu_hold), 32'(!ok));
        check_output("end_ready", 32'(in_ready), 0);
        check_output("end_count", 32'(words_loaded), n);
        check_output("end_pending", exp_q.size(), 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start_ready", 32'(in_ready), 1);
        check_output("start_hold", 32'(cpu_hold), 1);
        check_output("start_done", 32'(done), 0);
        check_output("start_err", 32'(err), 0);
        check_output("start_count", 32'(words_loaded), 0);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] none[$];
        int          n;
        logic [7:0]  mask;

        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        repeat (3) @(negedge clk);
        check_output("reset_ready", 32'(in_ready), 1);
        check_output("reset_we", 32'(imem_we), 0);
        check_output("reset_addr", 32'(imem_addr), 0);
        check_output("reset_wdata", imem_wdata, 0);
        check_output("reset_hold", 32'(cpu_hold), 1);
        check_output("reset_done", 32'(done), 0);
        check_output("reset_err", 32'(err), 0);
        check_output("reset_count", 32'(words_loaded), 0);
        rst = 1'b1;

        // Two-word program, good checksum, then the same with a bad one,
        // restart, and a clean resend.
        wq = '{32'h00500513, 32'h00100593};
        apply_stimulus(2, wq, 8'h00, 0, 0);
        do_start();
        apply_stimulus(2, wq, 8'h01, 0, 0);
        do_start();
        apply_stimulus(2, wq, 8'h00, 0, 0);
        do_start();

        // Length one past memory size.
        apply_stimulus(129, none, 8'h00, 0, 0);
        do_start();

        // Empty images.
        apply_stimulus(0, none, 8'h00, 0, 0);
        do_start();
        apply_stimulus(0, none, 8'h01, 0, 0);
        do_start();

        // One word with in_valid toggling every cycle.
        wq = '{32'hDEADBEEF};
        apply_stimulus(1, wq, 8'h00, 1, 0);
        do_start();

        // Reset after six data bytes of a three-word load, then reload.
        wq = '{32'h11223344, 32'hA5A55A5A, 32'h0BADF00D};
        apply_stimulus(3, wq, 8'h00, 0, 6);
        apply_stimulus(3, wq, 8'h00, 2, 0);
        do_start();

        // Exactly full memory.
        wq.delete();
        for (int i = 0; i < MAX_WORDS; i++) wq.push_back($urandom);
        apply_stimulus(MAX_WORDS, wq, 8'h00, 0, 0);
        do_start();

        // Randomized loads with random gaps and occasional bad checksums.
        for (int it = 0; it < 20; it++) begin
            n = int'($urandom_range(1, 8));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            apply_stimulus(n, wq, mask, 2, 0);
            do_start();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
